// File: rtl/cpu_pipe_pkg.sv
// Shared types for the pipeline control slice: controller state,
// PC source select and the per-stage enable/flush pair.
package cpu_pipe_pkg;

    // Controller state: normal flow, waiting on an I-fetch, or frozen behind a data access
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FETCH_WAIT = 2'd1,
        MEM_WAIT   = 2'd2
    } pipe_state_e;

    // PC source select
    typedef enum logic [1:0] {
        SEQ      = 2'd0,
        REDIRECT = 2'd1,
        EXC      = 2'd2
    } pc_sel_e;

    // Control for one pipeline register
    typedef struct packed {
        logic en;
        logic flush;
    } stage_ctl_t;

    // Indices of the pipeline registers that carry both an enable and a flush
    localparam int ST_FD  = 0;
    localparam int ST_DE  = 1;
    localparam int ST_EC  = 2;
    localparam int ST_CW  = 3;
    localparam int NUM_ST = 4;

    // Number of performance counters available when they are built in
    localparam int NUM_PERF = 4;

    // Register moves forward
    function automatic stage_ctl_t st_adv();
        return '{en: 1'b1, flush: 1'b0};
    endfunction

    // Register holds its content
    function automatic stage_ctl_t st_hold();
        return '{en: 1'b0, flush: 1'b0};
    endfunction

    // Register loads a bubble
    function automatic stage_ctl_t st_bubble();
        return '{en: 1'b0, flush: 1'b1};
    endfunction

endpackage

// File: rtl/cpu_pipe_perf_cnt.sv
// Single saturating event counter: counts cycles where inc is high and
// sticks at all-ones instead of wrapping.
module cpu_pipe_perf_cnt #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    // Count qualifying cycles, holding once the maximum value is reached
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/cpu_pipe_ctrl.sv
// Pipeline register enable/flush controller for a 5-stage pipe
// (PC, F/D, D/E, E/C, C/W). Resolves data-memory wait, commit exception,
// hazard stall, decode redirect and I-fetch wait by fixed priority, and
// remembers a redirect taken while a fetch is outstanding so the stale
// instruction is dropped when it returns.
// Optional feature macro: CPU_PIPE_PERF_EN adds four saturating
// PERF_W-bit stall/flush counters and their perf_* ports.
module cpu_pipe_ctrl
    import cpu_pipe_pkg::*;
#(
    parameter int PERF_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              hdu_stall,
    input  logic              redirect_decode,
    input  logic              imem_ready,
    input  logic              dmem_busy,
    input  logic              exc_commit,
    output logic              pc_en,
    output pc_sel_e           pc_sel,
    output logic              fd_en,
    output logic              fd_flush,
    output logic              de_en,
    output logic              de_flush,
    output logic              ec_en,
    output logic              ec_flush,
    output logic              cw_en,
    output logic              cw_flush
`ifdef CPU_PIPE_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_hdu_stall,
    output logic [PERF_W-1:0] perf_mem_stall,
    output logic [PERF_W-1:0] perf_fetch_stall,
    output logic [PERF_W-1:0] perf_flush
`endif
);

    // Registered state
    pipe_state_e state_reg, state_next;
    logic        redirect_pend_reg, redirect_pend_next;

    // Combinational control
    stage_ctl_t        stage_ctl [NUM_ST];
    logic [NUM_ST-1:0] stage_en;
    logic [NUM_ST-1:0] stage_flush;
    logic              pc_en_comb;
    pc_sel_e           pc_sel_comb;

    // Which request governed the PC this cycle (feeds the counters)
    logic win_hdu;
    logic win_mem;
    logic win_fetch;
    logic win_flush;

    // A returned fetch is stale only while a redirect is pending and we are still waiting on it
    logic stale_return;
    assign stale_return = redirect_pend_reg && (state_reg != RUN) && imem_ready;

    // Priority resolution of all requests into enables, flushes and the next state
    always_comb begin
        pc_en_comb         = 1'b1;
        pc_sel_comb        = SEQ;
        for (int i = 0; i < NUM_ST; i++) begin
            stage_ctl[i] = st_adv();
        end
        state_next         = RUN;
        redirect_pend_next = redirect_pend_reg;
        win_hdu            = 1'b0;
        win_mem            = 1'b0;
        win_fetch          = 1'b0;
        win_flush          = 1'b0;

        if (!reset) begin
            // Reset forces every register to bubble regardless of the clock
            pc_en_comb = 1'b0;
            for (int i = 0; i < NUM_ST; i++) begin
                stage_ctl[i] = st_bubble();
            end
            redirect_pend_next = 1'b0;
        end else if (dmem_busy) begin
            // Everything up to commit freezes; writeback receives a bubble
            pc_en_comb       = 1'b0;
            stage_ctl[ST_FD] = st_hold();
            stage_ctl[ST_DE] = st_hold();
            stage_ctl[ST_EC] = st_hold();
            stage_ctl[ST_CW] = st_bubble();
            state_next       = MEM_WAIT;
            win_mem          = 1'b1;
        end else if (exc_commit) begin
            // Trap: squash younger instructions, let the excepting one retire
            pc_sel_comb        = EXC;
            stage_ctl[ST_FD]   = st_bubble();
            stage_ctl[ST_DE]   = st_bubble();
            stage_ctl[ST_EC]   = st_bubble();
            redirect_pend_next = 1'b0;
            win_flush          = 1'b1;
        end else if (hdu_stall) begin
            // Hold fetch and decode, insert a bubble into execute.
            // Any outstanding fetch is still outstanding, so keep waiting on it.
            pc_en_comb       = 1'b0;
            stage_ctl[ST_FD] = st_hold();
            stage_ctl[ST_DE] = st_bubble();
            state_next       = (imem_ready && !redirect_pend_reg) ? RUN : FETCH_WAIT;
            win_hdu          = 1'b1;
        end else if (redirect_decode) begin
            // Load the target even if a fetch is in flight; remember to drop what comes back
            pc_sel_comb        = REDIRECT;
            stage_ctl[ST_FD]   = st_bubble();
            redirect_pend_next = !imem_ready;
            state_next         = imem_ready ? RUN : FETCH_WAIT;
            win_flush          = 1'b1;
        end else if (!imem_ready) begin
            // No instruction yet: hold PC, bubble into decode
            pc_en_comb       = 1'b0;
            stage_ctl[ST_FD] = st_bubble();
            state_next       = FETCH_WAIT;
            win_fetch        = 1'b1;
        end else if (stale_return) begin
            // Wrong-path instruction arrived: discard it and refetch from the redirected PC
            pc_en_comb         = 1'b0;
            stage_ctl[ST_FD]   = st_bubble();
            redirect_pend_next = 1'b0;
            win_fetch          = 1'b1;
        end
    end

    // Flatten the stage controls into per-register enable/flush vectors
    generate
        for (genvar gi = 0; gi < NUM_ST; gi++) begin : g_stage
            assign stage_en[gi]    = stage_ctl[gi].en;
            assign stage_flush[gi] = stage_ctl[gi].flush;

            // A register must never be told to load and bubble at once
            a_en_flush_excl : assert property (@(posedge clock) !(stage_en[gi] && stage_flush[gi]));
        end
    endgenerate

    assign pc_en    = pc_en_comb;
    assign pc_sel   = pc_sel_comb;
    assign fd_en    = stage_en[ST_FD];
    assign fd_flush = stage_flush[ST_FD];
    assign de_en    = stage_en[ST_DE];
    assign de_flush = stage_flush[ST_DE];
    assign ec_en    = stage_en[ST_EC];
    assign ec_flush = stage_flush[ST_EC];
    assign cw_en    = stage_en[ST_CW];
    assign cw_flush = stage_flush[ST_CW];

    // Controller state and the pending-redirect flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg         <= RUN;
            redirect_pend_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            redirect_pend_reg <= redirect_pend_next;
        end
    end

`ifdef CPU_PIPE_PERF_EN
    logic [NUM_PERF-1:0] perf_inc;
    logic [PERF_W-1:0]   perf_count [NUM_PERF];

    assign perf_inc = {win_flush, win_fetch, win_mem, win_hdu};

    generate
        for (genvar gi = 0; gi < NUM_PERF; gi++) begin : g_perf
            cpu_pipe_perf_cnt #(
                .W (PERF_W)
            ) u_cnt (
                .clock (clock),
                .reset (reset),
                .inc   (perf_inc[gi]),
                .count (perf_count[gi])
            );
        end
    endgenerate

    assign perf_hdu_stall   = perf_count[0];
    assign perf_mem_stall   = perf_count[1];
    assign perf_fetch_stall = perf_count[2];
    assign perf_flush       = perf_count[3];
`else
    logic unused_perf;
    assign unused_perf = ^{win_hdu, win_mem, win_fetch, win_flush};
`endif

endmodule

// File: tb/tb_cpu_pipe_ctrl.sv
// Self-checking bench for cpu_pipe_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// rule-table model of the controller.
module tb_cpu_pipe_ctrl;
    import cpu_pipe_pkg::*;

    localparam int TB_PERF_W = 4;
    localparam int PERF_MAX  = (1 << TB_PERF_W) - 1;

    logic    clock = 1'b0;
    logic    reset = 1'b0;
    logic    hdu_stall = 1'b0;
    logic    redirect_decode = 1'b0;
    logic    imem_ready = 1'b0;
    logic    dmem_busy = 1'b0;
    logic    exc_commit = 1'b0;
    logic    pc_en;
    pc_sel_e pc_sel;
    logic    fd_en, fd_flush, de_en, de_flush, ec_en, ec_flush, cw_en, cw_flush;
`ifdef CPU_PIPE_PERF_EN
    logic [TB_PERF_W-1:0] perf_hdu_stall, perf_mem_stall, perf_fetch_stall, perf_flush;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    cpu_pipe_ctrl #(
        .PERF_W (TB_PERF_W)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .hdu_stall       (hdu_stall),
        .redirect_decode (redirect_decode),
        .imem_ready      (imem_ready),
        .dmem_busy       (dmem_busy),
        .exc_commit      (exc_commit),
        .pc_en           (pc_en),
        .pc_sel          (pc_sel),
        .fd_en           (fd_en),
        .fd_flush        (fd_flush),
        .de_en           (de_en),
        .de_flush        (de_flush),
        .ec_en           (ec_en),
        .ec_flush        (ec_flush),
        .cw_en           (cw_en),
        .cw_flush        (cw_flush)
`ifdef CPU_PIPE_PERF_EN
        ,
        .perf_hdu_stall   (perf_hdu_stall),
        .perf_mem_stall   (perf_mem_stall),
        .perf_fetch_stall (perf_fetch_stall),
        .perf_flush       (perf_flush)
`endif
    );

    // Output bundle: {pc_en, pc_sel, fd_en,fd_flush, de_en,de_flush, ec_en,ec_flush, cw_en,cw_flush}
    logic [10:0] dut_vec;
    assign dut_vec = {pc_en, pc_sel, fd_en, fd_flush, de_en, de_flush,
                      ec_en, ec_flush, cw_en, cw_flush};

    // ---------------- reference model ----------------
    typedef enum int {R_RST, R_MEM, R_EXC, R_HDU, R_RED, R_FW, R_STALE, R_NORM} rule_t;

    logic model_pend = 1'b0;
    int   model_perf [4] = '{0, 0, 0, 0};

    // Which rule of the priority list governs this cycle
    function automatic rule_t pick_rule(input logic rst_n, input logic dm, input logic ex,
                                        input logic h, input logic rd, input logic im,
                                        input logic pend);
        if (!rst_n)  return R_RST;
        if (dm)      return R_MEM;
        if (ex)      return R_EXC;
        if (h)       return R_HDU;
        if (rd)      return R_RED;
        if (!im)     return R_FW;
        if (pend)    return R_STALE;
        return R_NORM;
    endfunction

    // Output pattern each rule demands
    function automatic logic [10:0] rule_vec(input rule_t r);
        case (r)
            R_RST:   return 11'b0_00_01_01_01_01;
            R_MEM:   return 11'b0_00_00_00_00_01;
            R_EXC:   return 11'b1_10_01_01_01_10;
            R_HDU:   return 11'b0_00_00_01_10_10;
            R_RED:   return 11'b1_01_01_10_10_10;
            R_FW:    return 11'b0_00_01_10_10_10;
            R_STALE: return 11'b0_00_01_10_10_10;
            default: return 11'b1_00_10_10_10_10;
        endcase
    endfunction

    // Per-cycle compare, then advance the model to what the next edge will register
    always @(negedge clock) begin
        rule_t       r;
        logic [10:0] exp_vec;
        r       = pick_rule(reset, dmem_busy, exc_commit, hdu_stall, redirect_decode,
                            imem_ready, model_pend);
        exp_vec = rule_vec(r);
        n_tests++;
        if (dut_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL outs t=%0t rule=%0d got=%b exp=%b", $time, r, dut_vec, exp_vec);
        end
`ifdef CPU_PIPE_PERF_EN
        begin
            logic [TB_PERF_W-1:0] got_p [4];
            got_p = '{perf_hdu_stall, perf_mem_stall, perf_fetch_stall, perf_flush};
            for (int k = 0; k < 4; k++) begin
                n_tests++;
                if (int'(got_p[k]) != model_perf[k]) begin
                    n_fail++;
                    $display("FAIL perf%0d t=%0t got=%0d exp=%0d", k, $time, got_p[k], model_perf[k]);
                end
            end
        end
`endif
        if (!reset) begin
            model_pend = 1'b0;
            for (int k = 0; k < 4; k++) model_perf[k] = 0;
        end else begin
            case (r)
                R_EXC, R_STALE: model_pend = 1'b0;
                R_RED:          model_pend = !imem_ready;
                default:        ;
            endcase
            case (r)
                R_HDU:          if (model_perf[0] < PERF_MAX) model_perf[0]++;
                R_MEM:          if (model_perf[1] < PERF_MAX) model_perf[1]++;
                R_FW, R_STALE:  if (model_perf[2] < PERF_MAX) model_perf[2]++;
                R_EXC, R_RED:   if (model_perf[3] < PERF_MAX) model_perf[3]++;
                default:        ;
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic h, input logic rd, input logic im,
                        input logic dm, input logic ex);
        @(posedge clock);
        #1;
        hdu_stall       = h;
        redirect_decode = rd;
        imem_ready      = im;
        dmem_busy       = dm;
        exc_commit      = ex;
        #1;
    endtask

    task automatic lit(input string name, input logic [10:0] exp_vec);
        n_tests++;
        if (dut_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%b exp=%b", name, $time, dut_vec, exp_vec);
        end
    endtask

    localparam logic [10:0] V_NORM = 11'b1_00_10_10_10_10;
    localparam logic [10:0] V_RST  = 11'b0_00_01_01_01_01;

    initial begin
        // Reset state
        #2;
        lit("reset_outs", V_RST);
        @(posedge clock);
        #1;
        reset      = 1'b1;
        imem_ready = 1'b1;

        // 1: idle flow
        repeat (10) begin
            step(0, 0, 1, 0, 0);
            lit("idle", V_NORM);
        end

        // 2: single-cycle hazard stall
        step(1, 0, 1, 0, 0);
        lit("hdu", 11'b0_00_00_01_10_10);
        step(0, 0, 1, 0, 0);
        lit("hdu_after", V_NORM);

        // 3: redirect while fetch outstanding, stale return dropped
        step(0, 1, 0, 0, 0);
        lit("redir_wait", 11'b1_01_01_10_10_10);
        repeat (2) begin
            step(0, 0, 0, 0, 0);
            lit("fetch_wait", 11'b0_00_01_10_10_10);
        end
        step(0, 0, 1, 0, 0);
        lit("stale_drop", 11'b0_00_01_10_10_10);
        step(0, 0, 1, 0, 0);
        lit("after_stale", V_NORM);

        // 4: data wait masks a pending exception, then the trap
        repeat (4) begin
            step(0, 0, 1, 1, 1);
            lit("mem_freeze", 11'b0_00_00_00_00_01);
        end
        step(0, 0, 1, 0, 1);
        lit("exc", 11'b1_10_01_01_01_10);
        step(0, 0, 1, 0, 0);
        lit("after_exc", V_NORM);

        // Simultaneous events
        step(1, 0, 0, 0, 0);
        lit("hdu_and_fetch", 11'b0_00_00_01_10_10);
        step(0, 1, 1, 0, 1);
        lit("exc_over_redir", 11'b1_10_01_01_01_10);
        step(0, 1, 1, 0, 0);
        lit("redir_ready", 11'b1_01_01_10_10_10);
        step(0, 0, 1, 0, 0);
        lit("no_pend_after_redir", V_NORM);

        // 5: asynchronous reset in the middle of a pending redirect wait
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        #1;
        reset = 1'b0;
        #1;
        lit("async_reset", V_RST);
        @(posedge clock);
        #1;
        reset = 1'b1;
        imem_ready = 1'b1;
        #1;
        lit("post_reset", V_NORM);
`ifdef CPU_PIPE_PERF_EN
        n_tests++;
        if ({perf_hdu_stall, perf_mem_stall, perf_fetch_stall, perf_flush} !== '0) begin
            n_fail++;
            $display("FAIL perf_reset got=%h exp=0",
                     {perf_hdu_stall, perf_mem_stall, perf_fetch_stall, perf_flush});
        end
        // 6: mem-stall counter saturation
        repeat (20) step(0, 0, 1, 1, 0);
        n_tests++;
        if (perf_mem_stall !== 4'd15) begin
            n_fail++;
            $display("FAIL perf_sat got=%0d exp=15", perf_mem_stall);
        end
`endif

        // Randomized traffic, checked by the per-cycle compare
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 8) == 0, ($urandom % 6) == 0, ($urandom % 4) != 0,
                 ($urandom % 10) == 0, ($urandom % 16) == 0);
        end

        step(0, 0, 1, 0, 0);
        @(posedge clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
